// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: steps a minterm counter through every input combination
// of a small combinational network, gives each minterm one settle cycle, and
// captures the returned response bit into a truth-table register.
// Optional feature macro: SWEEP_COMPARE_EN builds the compare-against-expected
// logic (err_count / pass). Without it pass and err_count stay zero and exp is
// ignored.
module truth_table_sweeper #(
    parameter int unsigned N_IN = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [N_IN-1:0]      stim,
    input  logic                 s,
    input  logic [2**N_IN-1:0]   exp,
    output logic [N_IN-1:0]      m,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   tbl,
    output logic                 pass,
    output logic [N_IN:0]        err_count
);

    localparam int unsigned N_MT = 2**N_IN;
    localparam int unsigned CW   = N_IN + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            busy_d;
    logic            done_d;
    logic [N_IN-1:0] m_q;
    logic            last_mt;
    logic            accept;
    logic            sample_exit;

    assign last_mt     = (m_q == N_IN'(N_MT - 1));
    assign accept      = (state_q == IDLE) && start;
    assign sample_exit = (state_q == SAMPLE);

    // Minterm index drives the network directly so stim and m never disagree.
    assign m    = m_q;
    assign stim = m_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one APPLY (settle) and one SAMPLE cycle per minterm.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = APPLY;
            APPLY:   state_d = SAMPLE;
            SAMPLE:  state_d = last_mt ? DONE : APPLY;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered flags line up with it.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            APPLY, SAMPLE: busy_d = 1'b1;
            DONE:          done_d = 1'b1;
            default:       ;
        endcase
    end

    // Registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
        end
    end

    // Minterm counter and truth-table capture; cleared on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= '0;
            tbl <= '0;
        end else if (accept) begin
            m_q <= '0;
            tbl <= '0;
        end else if (sample_exit) begin
            tbl[m_q] <= s;
            if (!last_mt) begin
                m_q <= m_q + N_IN'(1);
            end
        end
    end

`ifdef SWEEP_COMPARE_EN
    logic          mismatch;
    logic [N_IN:0] err_next;

    // Running mismatch count including the minterm being sampled this cycle.
    always_comb begin
        mismatch = (s != exp[m_q]);
        err_next = err_count + CW'(mismatch);
    end

    // Error counter and verdict; the verdict uses the count including the last minterm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            pass      <= 1'b0;
        end else if (accept) begin
            err_count <= '0;
            pass      <= 1'b0;
        end else if (sample_exit) begin
            err_count <= err_next;
            if (last_mt) begin
                pass <= (err_next == '0);
            end
        end
    end
`else
    logic unused_exp;

    assign unused_exp = ^exp;
    assign err_count  = '0;
    assign pass       = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: N_IN=2 instance driving a
// NAND(NOT a, b) network and N_IN=3 instance with a stim[0] loopback.
module tb_truth_table_sweeper;

`ifdef SWEEP_COMPARE_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start2, start3;
    logic       s2, s3;
    logic [1:0] stim2, m2;
    logic [3:0] exp2, tbl2;
    logic       busy2, done2, pass2;
    logic [2:0] err2;
    logic [2:0] stim3, m3;
    logic [7:0] exp3, tbl3;
    logic       busy3, done3, pass3;
    logic [3:0] err3;

    // Gate networks under exercise: a = stim[MSB], b = stim[0].
    assign s2 = ~(~stim2[1] & stim2[0]);
    assign s3 = stim3[0];

    truth_table_sweeper #(.N_IN(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .stim(stim2), .s(s2),
        .exp(exp2), .m(m2), .busy(busy2), .done(done2), .tbl(tbl2),
        .pass(pass2), .err_count(err2)
    );

    truth_table_sweeper #(.N_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .stim(stim3), .s(s3),
        .exp(exp3), .m(m3), .busy(busy3), .done(done3), .tbl(tbl3),
        .pass(pass3), .err_count(err3)
    );

    int         sel;
    int         cur_stim, cur_m, cur_err;
    int         cur_busy, cur_done, cur_pass, cur_tbl;

    // Observation mux for whichever instance the current test targets.
    always_comb begin
        if (sel == 3) begin
            cur_stim = int'(stim3); cur_m = int'(m3); cur_err = int'(err3);
            cur_busy = int'(busy3); cur_done = int'(done3);
            cur_pass = int'(pass3); cur_tbl = int'(tbl3);
        end else begin
            cur_stim = int'(stim2); cur_m = int'(m2); cur_err = int'(err2);
            cur_busy = int'(busy2); cur_done = int'(done2);
            cur_pass = int'(pass2); cur_tbl = int'(tbl2);
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel == 3) start3 = v;
        else          start2 = v;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_stim"}, cur_stim, 0);
        check({tag, "_m"},    cur_m,    0);
        check({tag, "_busy"}, cur_busy, 0);
        check({tag, "_done"}, cur_done, 0);
        check({tag, "_tbl"},  cur_tbl,  0);
        check({tag, "_pass"}, cur_pass, 0);
        check({tag, "_err"},  cur_err,  0);
    endtask

    // One start pulse, walk the sweep checking stim each cycle, then latency and done width.
    task automatic sweep(input int n, input logic [7:0] e, input int restart_at);
        int lat;
        sel  = n;
        exp3 = e;
        exp2 = e[3:0];
        @(negedge clk);
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        check("busy_after_start", cur_busy, 1);
        check("m_after_start", cur_m, 0);
        lat = 0;
        while (cur_done == 0 && lat < 100) begin
            check("stim_seq", cur_stim, lat / 2);
            set_start(lat == restart_at);
            @(posedge clk); #1;
            lat++;
        end
        set_start(1'b0);
        check("latency", lat, 2 * (1 << n));
        check("busy_in_done", cur_busy, 0);
        @(posedge clk); #1;
        check("done_one_cycle", cur_done, 0);
        check("idle_busy", cur_busy, 0);
    endtask

    task automatic wait_done(input string name);
        int cyc;
        cyc = 0;
        while (cur_done == 0 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check(name, cur_done, 1);
    endtask

    typedef struct {
        int         n;
        logic [7:0] exp;
        logic [7:0] tbl;
        logic       pass;
        int         err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{2, 8'h0D, 8'h0D, 1'b1, 0};
        vecs[1] = '{2, 8'h0F, 8'h0D, 1'b0, 1};
        vecs[2] = '{2, 8'h00, 8'h0D, 1'b0, 3};
        vecs[3] = '{2, 8'h02, 8'h0D, 1'b0, 4};
        vecs[4] = '{3, 8'hAA, 8'hAA, 1'b1, 0};
        vecs[5] = '{3, 8'h55, 8'hAA, 1'b0, 8};
        vecs[6] = '{3, 8'hAB, 8'hAA, 1'b0, 1};

        rst_n  = 1'b0;
        start2 = 1'b0;
        start3 = 1'b0;
        exp2   = '0;
        exp3   = '0;
        sel    = 2;
        #12;
        check_zero("reset2");
        sel = 3;
        #1;
        check_zero("reset3");
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven sweeps across both instances.
        for (int i = 0; i < 7; i++) begin
            sweep(vecs[i].n, vecs[i].exp, -1);
            check($sformatf("vec%0d_tbl", i), cur_tbl, int'(vecs[i].tbl));
            check($sformatf("vec%0d_pass", i), cur_pass, CMP ? int'(vecs[i].pass) : 0);
            check($sformatf("vec%0d_err", i), cur_err, CMP ? vecs[i].err : 0);
            check($sformatf("vec%0d_hold_m", i), cur_m, (1 << vecs[i].n) - 1);
        end

        // Start re-pulsed at m=2 mid-sweep must be ignored.
        sweep(2, 8'h0D, 4);
        check("restart_tbl", cur_tbl, 'hD);
        repeat (3) begin
            @(posedge clk); #1;
            check("restart_no_resweep", cur_busy + cur_done, 0);
        end

        // Reset during SAMPLE of m=1 clears everything immediately.
        sel  = 2;
        exp2 = 4'hD;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_m", cur_m, 1);
        check("pre_reset_tbl", cur_tbl, 1);
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("no_resume", cur_busy, 0);
        end
        sweep(2, 8'h0D, -1);
        check("post_reset_tbl", cur_tbl, 'hD);
        check("post_reset_pass", cur_pass, CMP ? 1 : 0);

        // Start held high: back-to-back sweeps with IDLE gap and table clear.
        sel  = 2;
        exp2 = 4'hF;
        @(negedge clk);
        start2 = 1'b1;
        wait_done("b2b_first_done");
        check("b2b_first_tbl", cur_tbl, 'hD);
        @(posedge clk); #1;
        check("b2b_idle_busy", cur_busy, 0);
        check("b2b_idle_done", cur_done, 0);
        check("b2b_idle_tbl_held", cur_tbl, 'hD);
        check("b2b_idle_err_held", cur_err, CMP ? 1 : 0);
        @(posedge clk); #1;
        check("b2b_restart_busy", cur_busy, 1);
        check("b2b_restart_tbl", cur_tbl, 0);
        check("b2b_restart_err", cur_err, 0);
        check("b2b_restart_m", cur_m, 0);
        @(negedge clk);
        start2 = 1'b0;
        wait_done("b2b_second_done");
        check("b2b_second_tbl", cur_tbl, 'hD);
        check("b2b_second_pass", cur_pass, 0);
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter N_IN, default 2, number of stimulus inputs driven into the combinational unit under exercise (legal 1..4).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, sweep request, sampled in IDLE only.
REQ-005 SHALL have port stim, output, N_IN, minterm applied to the downstream gate network (stim[N_IN-1] = MSB variable, e.g. a; stim[0] = LSB, e.g. b).
REQ-006 SHALL have port s, input, 1, response bit returned by the gate network.
REQ-007 SHALL have port exp, input, 2**N_IN, expected truth table, bit i = expected s for minterm i.
REQ-008 SHALL have port m, output, N_IN, index of minterm currently applied.
REQ-009 SHALL have port busy, output, 1, high in APPLY and SAMPLE.
REQ-010 SHALL have port done, output, 1, one-cycle pulse at sweep completion.
REQ-011 SHALL have port tbl, output, 2**N_IN, captured truth table, bit i = s for minterm i.
REQ-012 SHALL have port pass, output, 1, sweep matched exp.
REQ-013 SHALL have port err_count, output, N_IN+1, number of mismatching minterms.

Function
REQ-014 SHALL implement FSM states IDLE, APPLY, SAMPLE, DONE.
REQ-015 SHALL in IDLE with start=1 at an edge: go to APPLY, m=0, tbl=0, err_count=0, pass=0.
REQ-016 SHALL drive stim = m continuously; stim stable across the APPLY and SAMPLE cycles of each minterm (one settle cycle).
REQ-017 SHALL go APPLY -> SAMPLE unconditionally on the next edge.
REQ-018 SHALL at the SAMPLE-exit edge write s into tbl[m]; if m < 2**N_IN-1: m increments, go to APPLY; else m holds, go to DONE.
REQ-019 SHALL hold done=1 for exactly the one DONE cycle, then return to IDLE; busy=0 in IDLE and DONE.
REQ-020 SHALL give latency: start accepted at edge k -> done high after edge k+2*2**N_IN (edge k+8 for N_IN=2).
REQ-021 SHALL ignore start while busy or in DONE; no restart, no clearing.
REQ-022 SHALL hold tbl, pass, err_count after DONE until the next accepted start.
REQ-023 SHALL sample exp only at SAMPLE-exit edges; exp changes mid-sweep affect only later minterms.

Reset
REQ-024 SHALL on rst_n=0, at any time including mid-sweep, immediately force IDLE, m=0, stim=0, busy=0, done=0, tbl=0, pass=0, err_count=0.
REQ-025 SHALL require a fresh start after rst_n release; no sweep resumes.

Configuration
REQ-026 SHALL compile comparison logic only when macro SWEEP_COMPARE_EN is defined.
REQ-027 SHALL with SWEEP_COMPARE_EN: at each SAMPLE-exit edge increment err_count if s != exp[m]; at the DONE transition set pass = (final err_count == 0).
REQ-028 SHALL without SWEEP_COMPARE_EN: tie pass=0 and err_count=0, ignore exp; capture, FSM and timing unchanged.

Verification
REQ-029 SHALL cover: N_IN=2, gate network s=NAND(NOT a, b), exp=4'b1101, start pulse -> tbl=4'b1101, pass=1, err_count=0, done pulse 8 edges after start edge.
REQ-030 SHALL cover: same network, exp=4'b1111 -> tbl=4'b1101, err_count=1, pass=0 (compare built) / pass=0, err_count=0 (compare not built).
REQ-031 SHALL cover: N_IN=3, loopback s=stim[0], exp=8'hAA -> tbl=8'hAA, pass=1, stim sequence 0..7 each held 2 cycles.
REQ-032 SHALL cover: start re-pulsed at m=2 mid-sweep -> ignored; sweep completes normally, single done pulse.
REQ-033 SHALL cover: rst_n low during SAMPLE of m=1 -> all outputs zero at once, FSM IDLE; next start gives a full correct sweep.
REQ-034 SHALL cover: start held high continuously -> back-to-back sweeps, each starting in IDLE one cycle after DONE, tbl cleared at each start.
